// File: rtl/pcie_us_cfg_pkg.sv
// Shared types and constants for the cfg_mgmt responder: FSM encoding,
// latency bounds, function/dword identifiers and the byte-merge helper.
package pcie_us_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = $clog2(LATENCY_MAX + 1);

    localparam logic [7:0] FUNC0_NUM = 8'd0;

    localparam int DW_ID         = 0;
    localparam int DW_CMD_STATUS = 1;
    localparam int DW_CLASS_REV  = 2;
    localparam int DW_BIST_HDR   = 3;

    // Byte i of the result comes from new_dw when be[i] is set, else from old_dw.
    function automatic logic [31:0] be_merge(input logic [31:0] old_dw,
                                             input logic [31:0] new_dw,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_dw;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_dw[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/pcie_us_cfg_regfile.sv
// Dword register file backing the config space: byte-enable writes,
// a read-only low region and the ID value in dword 0 after reset.
module pcie_us_cfg_regfile
    import pcie_us_cfg_pkg::*;
#(
    parameter int          IMPL_ADDR_WIDTH = 6,
    parameter int          RO_DWORDS       = 4,
    parameter logic [31:0] ID_DWORD0       = 32'h90381234
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we_i,
    input  logic [IMPL_ADDR_WIDTH-1:0] waddr_i,
    input  logic [31:0]                wdata_i,
    input  logic [3:0]                 be_i,
    input  logic [IMPL_ADDR_WIDTH-1:0] raddr_i,
    output logic [31:0]                rdata_o
);

    localparam int DEPTH = 2 ** IMPL_ADDR_WIDTH;

    logic [31:0] mem_q [DEPTH];

    // Writes into the read-only window are dropped here, so callers only gate on hit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= (i == DW_ID) ? ID_DWORD0 : 32'h0;
            end
        end else if (we_i && (int'(waddr_i) >= RO_DWORDS)) begin
            mem_q[waddr_i] <= be_merge(mem_q[waddr_i], wdata_i, be_i);
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pcie_us_cfg_mgmt_responder.sv
// Hard-IP side of the UltraScale cfg_mgmt interface: accepts one held
// request, completes it LATENCY cycles later, then ignores one cycle.
module pcie_us_cfg_mgmt_responder
    import pcie_us_cfg_pkg::*;
#(
    parameter int          ADDR_WIDTH      = 10,
    parameter int          IMPL_ADDR_WIDTH = 6,
    parameter int          RO_DWORDS       = 4,
    parameter logic [31:0] ID_DWORD0       = 32'h90381234,
    parameter int          LATENCY         = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] cfg_mgmt_addr,
    input  logic [7:0]            cfg_mgmt_function_number,
    input  logic                  cfg_mgmt_write,
    input  logic [31:0]           cfg_mgmt_write_data,
    input  logic [3:0]            cfg_mgmt_byte_enable,
    input  logic                  cfg_mgmt_read,
    output logic [31:0]           cfg_mgmt_read_data,
    output logic                  cfg_mgmt_read_write_done,
    output logic                  stat_conflict,
    output logic [15:0]           stat_access_count,
    output state_t                dbg_state_o
);

    // LATENCY is expected within LATENCY_MIN..LATENCY_MAX.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            fn_q;
    logic                  wr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            be_q;
    logic [31:0]           read_data_q;
    logic                  done_q;
    logic                  conflict_q;
    logic [15:0]           count_q;

    logic        target_hit;
    logic        req_held;
    logic        rf_we;
    logic [31:0] rf_rdata;

    assign target_hit = ((addr_q >> IMPL_ADDR_WIDTH) == '0) && (fn_q == FUNC0_NUM);
    // A conflicting request was accepted as a write, so the write line is the one tracked.
    assign req_held   = wr_q ? cfg_mgmt_write : cfg_mgmt_read;
    assign rf_we      = (state_q == ST_DONE) && wr_q && target_hit;

    pcie_us_cfg_regfile #(
        .IMPL_ADDR_WIDTH (IMPL_ADDR_WIDTH),
        .RO_DWORDS       (RO_DWORDS),
        .ID_DWORD0       (ID_DWORD0)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (rf_we),
        .waddr_i (addr_q[IMPL_ADDR_WIDTH-1:0]),
        .wdata_i (wdata_q),
        .be_i    (be_q),
        .raddr_i (addr_q[IMPL_ADDR_WIDTH-1:0]),
        .rdata_o (rf_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            fn_q        <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
            read_data_q <= '0;
            done_q      <= 1'b0;
            conflict_q  <= 1'b0;
            count_q     <= '0;
        end else begin
            done_q      <= 1'b0;
            conflict_q  <= 1'b0;
            read_data_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (cfg_mgmt_read || cfg_mgmt_write) begin
                        addr_q     <= cfg_mgmt_addr;
                        fn_q       <= cfg_mgmt_function_number;
                        wr_q       <= cfg_mgmt_write;
                        wdata_q    <= cfg_mgmt_write_data;
                        be_q       <= cfg_mgmt_byte_enable;
                        cnt_q      <= CNT_INIT;
                        conflict_q <= cfg_mgmt_read && cfg_mgmt_write;
                        state_q    <= (LATENCY == 1) ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!req_held) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    count_q <= count_q + 16'd1;
                    if (!wr_q && target_hit) read_data_q <= rf_rdata;
                    state_q <= ST_HOLD;
                end
                ST_HOLD: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cfg_mgmt_read_data       = read_data_q;
    assign cfg_mgmt_read_write_done = done_q;
    assign stat_conflict            = conflict_q;
    assign stat_access_count        = count_q;
    assign dbg_state_o              = state_q;

endmodule

// File: tb/tb_pcie_us_cfg_mgmt_responder.sv
// Directed bench for the cfg_mgmt responder: a vector table on a LATENCY=2
// instance plus hand sequences for hold, mid-WAIT reset and LATENCY=4 abort.
module tb_pcie_us_cfg_mgmt_responder;
    import pcie_us_cfg_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst4_n;
    logic [9:0]  addr;
    logic [7:0]  fn;
    logic        wr, rd;
    logic [31:0] wdata;
    logic [3:0]  be;

    logic [31:0] rdata_a, rdata_b;
    logic        done_a, done_b, conf_a, conf_b;
    logic [15:0] cnt_a, cnt_b;
    state_t      state_a, state_b;

    logic use_b = 1'b0;
    wire [31:0] cur_rdata = use_b ? rdata_b : rdata_a;
    wire        cur_done  = use_b ? done_b  : done_a;
    wire        cur_conf  = use_b ? conf_b  : conf_a;
    wire [15:0] cur_cnt   = use_b ? cnt_b   : cnt_a;
    wire [1:0]  cur_state = use_b ? state_b : state_a;

    pcie_us_cfg_mgmt_responder #(.LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_mgmt_addr(addr), .cfg_mgmt_function_number(fn),
        .cfg_mgmt_write(wr), .cfg_mgmt_write_data(wdata), .cfg_mgmt_byte_enable(be),
        .cfg_mgmt_read(rd), .cfg_mgmt_read_data(rdata_a), .cfg_mgmt_read_write_done(done_a),
        .stat_conflict(conf_a), .stat_access_count(cnt_a), .dbg_state_o(state_a)
    );

    pcie_us_cfg_mgmt_responder #(.LATENCY(4)) dut4 (
        .clk(clk), .rst_n(rst4_n), .cfg_mgmt_addr(addr), .cfg_mgmt_function_number(fn),
        .cfg_mgmt_write(wr), .cfg_mgmt_write_data(wdata), .cfg_mgmt_byte_enable(be),
        .cfg_mgmt_read(rd), .cfg_mgmt_read_data(rdata_b), .cfg_mgmt_read_write_done(done_b),
        .stat_conflict(conf_b), .stat_access_count(cnt_b), .dbg_state_o(state_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives one request, holds it until done (bounded), drops it and absorbs HOLD.
    task automatic access(input logic r, input logic w, input logic [9:0] a, input logic [7:0] f,
                          input logic [31:0] d, input logic [3:0] b,
                          output int lat, output logic [31:0] rdat, output logic conf,
                          output logic [15:0] cnt);
        rd = r; wr = w; addr = a; fn = f; wdata = d; be = b;
        @(posedge clk); #1;
        conf = cur_conf;
        lat  = -1;
        rdat = 'x;
        cnt  = cur_cnt;
        if (cur_done) begin lat = 0; rdat = cur_rdata; end
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            @(posedge clk); #1;
            if (cur_done) begin lat = n; rdat = cur_rdata; cnt = cur_cnt; end
        end
        rd = 1'b0; wr = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        r;
        logic        w;
        logic [9:0]  a;
        logic [7:0]  f;
        logic [31:0] d;
        logic [3:0]  b;
        logic [31:0] exp_rd;
        logic        exp_conf;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs[NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] rdat;
        logic        conf;
        logic [15:0] cnt;
        int          exp_cnt;
        int          n_done;
        int          done_at;

        vecs[0]  = '{1'b1, 1'b0, 10'd0,   8'd0, 32'h0,        4'h0, 32'h90381234, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 10'd8,   8'd0, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
        vecs[2]  = '{1'b1, 1'b0, 10'd8,   8'd0, 32'h0,        4'h0, 32'h00BB00DD, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 10'd1,   8'd0, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 1'b1, 10'd100, 8'd0, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b0};
        vecs[5]  = '{1'b1, 1'b0, 10'd1,   8'd0, 32'h0,        4'h0, 32'h0,        1'b0};
        vecs[6]  = '{1'b1, 1'b0, 10'd100, 8'd0, 32'h0,        4'h0, 32'h0,        1'b0};
        vecs[7]  = '{1'b1, 1'b1, 10'd9,   8'd0, 32'h12345678, 4'hF, 32'h0,        1'b1};
        vecs[8]  = '{1'b1, 1'b0, 10'd9,   8'd0, 32'h0,        4'h0, 32'h12345678, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 10'd8,   8'd0, 32'h11223344, 4'hA, 32'h0,        1'b0};
        vecs[10] = '{1'b1, 1'b0, 10'd8,   8'd0, 32'h0,        4'h0, 32'h11BB33DD, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 10'd64,  8'd0, 32'h0,        4'h0, 32'h0,        1'b0};
        vecs[12] = '{1'b0, 1'b1, 10'd63,  8'd0, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
        vecs[13] = '{1'b1, 1'b0, 10'd63,  8'd0, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 10'd3,   8'd0, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b0};
        vecs[15] = '{1'b1, 1'b0, 10'd3,   8'd0, 32'h0,        4'h0, 32'h0,        1'b0};
        vecs[16] = '{1'b0, 1'b1, 10'd4,   8'd0, 32'h5A5A5A5A, 4'hF, 32'h0,        1'b0};
        vecs[17] = '{1'b1, 1'b0, 10'd4,   8'd0, 32'h0,        4'h0, 32'h5A5A5A5A, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 10'd10,  8'd1, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[19] = '{1'b1, 1'b0, 10'd10,  8'd0, 32'h0,        4'h0, 32'h0,        1'b0};
        vecs[20] = '{1'b0, 1'b1, 10'd10,  8'd0, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[21] = '{1'b1, 1'b0, 10'd10,  8'd1, 32'h0,        4'h0, 32'h0,        1'b0};
        vecs[22] = '{1'b1, 1'b0, 10'd10,  8'd0, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[23] = '{1'b0, 1'b1, 10'd0,   8'd0, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b0};
        vecs[24] = '{1'b1, 1'b0, 10'd0,   8'd0, 32'h0,        4'h0, 32'h90381234, 1'b0};
        vecs[25] = '{1'b0, 1'b1, 10'd4,   8'd0, 32'h00000000, 4'h0, 32'h0,        1'b0};
        vecs[26] = '{1'b1, 1'b0, 10'd4,   8'd0, 32'h0,        4'h0, 32'h5A5A5A5A, 1'b0};
        vecs[27] = '{1'b1, 1'b0, 10'd964, 8'd0, 32'h0,        4'h0, 32'h0,        1'b0};

        rst_n = 1'b0; rst4_n = 1'b0;
        rd = 1'b0; wr = 1'b0; addr = '0; fn = '0; wdata = '0; be = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata", rdata_a, 32'h0);
        check("rst_done", 32'(done_a), 32'h0);
        check("rst_conflict", 32'(conf_a), 32'h0);
        check("rst_count", 32'(cnt_a), 32'h0);
        check("rst_state", 32'(state_a), 32'(ST_IDLE));
        rst_n = 1'b1;
        @(posedge clk); #1;

        exp_cnt = 0;
        for (int i = 0; i < NV; i++) begin
            access(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].f, vecs[i].d, vecs[i].b,
                   lat, rdat, conf, cnt);
            exp_cnt++;
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
            check($sformatf("v%0d_rdata", i), rdat, vecs[i].exp_rd);
            check($sformatf("v%0d_conflict", i), 32'(conf), 32'(vecs[i].exp_conf));
            check($sformatf("v%0d_count", i), 32'(cnt), 32'(exp_cnt));
        end

        // Request stays high through the HOLD edge: must not be re-accepted.
        rd = 1'b1; wr = 1'b0; addr = 10'd63; fn = 8'd0;
        @(posedge clk); #1;
        n_done = 0; done_at = -1;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            if (done_a) begin
                n_done++;
                if (done_at < 0) begin
                    done_at = n;
                    check("hold_rdata", rdata_a, 32'hCAFEF00D);
                end
            end
            if (done_at >= 0 && n == done_at + 1) rd = 1'b0;
        end
        rd = 1'b0;
        exp_cnt++;
        check("hold_done_pulses", 32'(n_done), 32'd1);
        check("hold_done_latency", 32'(done_at), 32'd2);
        check("hold_count", 32'(cnt_a), 32'(exp_cnt));

        // Reset asserted while a write to dword 8 sits in WAIT.
        wr = 1'b1; addr = 10'd8; wdata = 32'h55555555; be = 4'hF;
        @(posedge clk); #1;
        check("midrst_in_wait", 32'(state_a), 32'(ST_WAIT));
        rst_n = 1'b0; wr = 1'b0;
        @(posedge clk); #1;
        check("midrst_done", 32'(done_a), 32'h0);
        check("midrst_count", 32'(cnt_a), 32'h0);
        check("midrst_state", 32'(state_a), 32'(ST_IDLE));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_no_late_done", 32'(done_a), 32'h0);
        access(1'b1, 1'b0, 10'd8, 8'd0, 32'h0, 4'h0, lat, rdat, conf, cnt);
        check("midrst_dw8", rdat, 32'h0);
        check("midrst_count_after", 32'(cnt), 32'd1);
        access(1'b1, 1'b0, 10'd0, 8'd0, 32'h0, 4'h0, lat, rdat, conf, cnt);
        check("midrst_dw0", rdat, 32'h90381234);

        // LATENCY=4 instance: abort by dropping the request, then normal accesses.
        use_b = 1'b1;
        rst4_n = 1'b1;
        @(posedge clk); #1;
        check("l4_rst_count", 32'(cnt_b), 32'h0);
        rd = 1'b1; addr = 10'd0; fn = 8'd0;
        @(posedge clk); #1;
        check("l4_abort_in_wait", 32'(state_b), 32'(ST_WAIT));
        rd = 1'b0;
        n_done = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (done_b) n_done++;
        end
        check("l4_abort_no_done", 32'(n_done), 32'd0);
        check("l4_abort_count", 32'(cnt_b), 32'd0);
        check("l4_abort_state", 32'(state_b), 32'(ST_IDLE));
        access(1'b1, 1'b0, 10'd0, 8'd0, 32'h0, 4'h0, lat, rdat, conf, cnt);
        check("l4_read_latency", 32'(lat), 32'd4);
        check("l4_read_rdata", rdat, 32'h90381234);
        check("l4_read_count", 32'(cnt), 32'd1);

        // Aborted write must not commit.
        wr = 1'b1; addr = 10'd5; wdata = 32'hA5A5A5A5; be = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        wr = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("l4_wabort_count", 32'(cnt_b), 32'd1);
        access(1'b1, 1'b0, 10'd5, 8'd0, 32'h0, 4'h0, lat, rdat, conf, cnt);
        check("l4_wabort_dw5", rdat, 32'h0);
        check("l4_wabort_count_after", 32'(cnt), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
